// File: rtl/biquad_pkg.sv
// Shared types and constants for the biquad MAC scheduler.
package biquad_pkg;

  localparam int DATAWIDTH_DFLT = 12;
  localparam int COEFWIDTH_DFLT = 16;

  // Accumulator width and output scaling shift at the default widths.
  localparam int ACCWIDTH = DATAWIDTH_DFLT + COEFWIDTH_DFLT + 5;
  localparam int SHIFT    = COEFWIDTH_DFLT - 2;

  // Tap issue order: feed-forward taps first, then the two feedback taps.
  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Value substituted for the most-negative coefficient so its magnitude fits COEFWIDTH-1 bits.
  function automatic int coef_clamp(input int cw);
    return -((2 ** (cw - 1)) - 1);
  endfunction

endpackage

// File: rtl/bq_sat.sv
// Signed saturator: clamps an IN_W-bit signed value into OUT_W bits.
module bq_sat #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 12
) (
  input  logic signed [IN_W-1:0]  din_i,
  output logic signed [OUT_W-1:0] dout_o
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  // Clip to the representable range, otherwise pass the low bits through.
  always_comb begin
    if (din_i > MAX_V) begin
      dout_o = MAX_V[OUT_W-1:0];
    end else if (din_i < MIN_V) begin
      dout_o = MIN_V[OUT_W-1:0];
    end else begin
      dout_o = din_i[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/biquad_mac_sched.sv
// Direct-form-I biquad sequencer sharing one external unsigned multiplier over five taps.
// Optional macro BQ_MULT_PIPE_EN: registers the multiplier result (and its sign) before
// accumulation, stretching MAC to six cycles.
//
//   state   | meaning
//   IDLE    | waiting for a sample; clear zeroes the filter history here
//   MAC     | one tap per cycle through the shared multiplier
//   OUT     | result presented, held until out_ready
module biquad_mac_sched
  import biquad_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DFLT,
  parameter int COEFWIDTH = COEFWIDTH_DFLT
) (
  input  logic                              clk,
  input  logic                              nreset,
  input  logic                              clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATAWIDTH-1:0]              in_data,
  input  logic [COEFWIDTH-1:0]              coef_b0,
  input  logic [COEFWIDTH-1:0]              coef_b1,
  input  logic [COEFWIDTH-1:0]              coef_b2,
  input  logic [COEFWIDTH-1:0]              coef_a1,
  input  logic [COEFWIDTH-1:0]              coef_a2,
  output logic [COEFWIDTH-2:0]              mul_a,
  output logic [DATAWIDTH+2:0]              mul_b,
  input  logic [DATAWIDTH+COEFWIDTH+1:0]    mul_r,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATAWIDTH-1:0]              out_data
);

  localparam int OPW  = DATAWIDTH + 3;
  localparam int PRW  = DATAWIDTH + COEFWIDTH + 2;
  // Package values are for the default widths; follow any parameter override.
  localparam int ACCW = ACCWIDTH + (DATAWIDTH - DATAWIDTH_DFLT) + (COEFWIDTH - COEFWIDTH_DFLT);
  localparam int SH   = SHIFT + (COEFWIDTH - COEFWIDTH_DFLT);
  localparam int YW   = ACCW - SH;

  localparam logic signed [COEFWIDTH-1:0] COEF_MOST_NEG = {1'b1, {(COEFWIDTH-1){1'b0}}};
  localparam logic signed [COEFWIDTH-1:0] COEF_CLAMP    = COEFWIDTH'(coef_clamp(COEFWIDTH));

`ifdef BQ_MULT_PIPE_EN
  localparam logic [2:0] LAST_CNT = 3'd5;
`else
  localparam logic [2:0] LAST_CNT = 3'd4;
`endif

  state_e                       state_q, state_d;
  logic [2:0]                   cnt_q, cnt_d;
  logic signed [ACCW-1:0]       acc_q, acc_d;
  logic signed [DATAWIDTH-1:0]  x_q, x_d, x1_q, x1_d, x2_q, x2_d;
  logic signed [OPW-1:0]        y1_q, y1_d, y2_q, y2_d;
  logic signed [COEFWIDTH-1:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, a1_q, a1_d, a2_q, a2_d;
  logic signed [DATAWIDTH-1:0]  out_q, out_d;

  logic signed [COEFWIDTH-1:0]  coef_sel, coef_cl;
  logic signed [OPW-1:0]        op_sel;
  logic [COEFWIDTH-2:0]         coef_mag;
  logic [OPW-1:0]               op_mag;
  logic                         coef_neg, op_neg, tap_live, sgn_now;
  logic [PRW-1:0]               prod_use;
  logic                         sgn_use, acc_en;
  logic signed [ACCW-1:0]       term_pos, acc_sum;
  logic signed [YW-1:0]         yfull;
  logic signed [OPW-1:0]        y_state;
  logic signed [DATAWIDTH-1:0]  y_out;

  // Pick the coefficient/operand pair for the current tap and split into sign and magnitude.
  always_comb begin
    coef_sel = '0;
    op_sel   = '0;
    case (cnt_q)
      TAP_B0:  begin coef_sel = b0_q; op_sel = OPW'(x_q);  end
      TAP_B1:  begin coef_sel = b1_q; op_sel = OPW'(x1_q); end
      TAP_B2:  begin coef_sel = b2_q; op_sel = OPW'(x2_q); end
      TAP_A1:  begin coef_sel = a1_q; op_sel = y1_q;       end
      TAP_A2:  begin coef_sel = a2_q; op_sel = y2_q;       end
      default: begin coef_sel = '0;   op_sel = '0;         end
    endcase
    coef_cl  = (coef_sel == COEF_MOST_NEG) ? COEF_CLAMP : coef_sel;
    coef_neg = coef_cl[COEFWIDTH-1];
    coef_mag = coef_neg ? (COEFWIDTH-1)'(-coef_cl) : coef_cl[COEFWIDTH-2:0];
    op_neg   = op_sel[OPW-1];
    op_mag   = op_neg ? -op_sel : op_sel;
    tap_live = (state_q == ST_MAC) && (cnt_q <= TAP_A2);
    mul_a    = tap_live ? coef_mag : '0;
    mul_b    = tap_live ? op_mag : '0;
    // Feedback taps are subtracted, hence the extra inversion from TAP_A1 on.
    sgn_now  = coef_neg ^ op_neg ^ (cnt_q >= TAP_A1);
  end

`ifdef BQ_MULT_PIPE_EN
  logic [PRW-1:0] prod_q;
  logic           sgn_q;

  // Product and its sign travel together so the accumulate lags the multiply by one cycle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      prod_q <= '0;
      sgn_q  <= 1'b0;
    end else begin
      prod_q <= mul_r;
      sgn_q  <= sgn_now;
    end
  end

  assign prod_use = prod_q;
  assign sgn_use  = sgn_q;
  assign acc_en   = (state_q == ST_MAC) && (cnt_q != TAP_B0);
`else
  assign prod_use = mul_r;
  assign sgn_use  = sgn_now;
  assign acc_en   = (state_q == ST_MAC);
`endif

  // Signed accumulate of the current product, then rescale from Q2.14 back to sample units.
  always_comb begin
    term_pos = $signed(ACCW'(prod_use));
    acc_sum  = acc_q;
    if (acc_en) begin
      acc_sum = sgn_use ? (acc_q - term_pos) : (acc_q + term_pos);
    end
    yfull = YW'(acc_sum >>> SH);
  end

  bq_sat #(.IN_W(YW), .OUT_W(OPW)) u_sat_state (
    .din_i  (yfull),
    .dout_o (y_state)
  );

  bq_sat #(.IN_W(YW), .OUT_W(DATAWIDTH)) u_sat_out (
    .din_i  (yfull),
    .dout_o (y_out)
  );

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          x1_d = '0;
          x2_d = '0;
          y1_d = '0;
          y2_d = '0;
        end else if (in_valid) begin
          x_d     = $signed(in_data);
          b0_d    = $signed(coef_b0);
          b1_d    = $signed(coef_b1);
          b2_d    = $signed(coef_b2);
          a1_d    = $signed(coef_a1);
          a2_d    = $signed(coef_a2);
          cnt_d   = TAP_B0;
          acc_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_CNT) begin
          y1_d    = y_state;
          y2_d    = y1_q;
          x2_d    = x1_q;
          x1_d    = x_q;
          out_d   = y_out;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial sum and the filter history.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_q;

endmodule

// File: tb/tb_biquad_mac_sched.sv
// Bench for biquad_mac_sched: behavioural filter model plus per-cycle output compare,
// directed literal scenarios and a randomized sample stream.
module tb_biquad_mac_sched;
  import biquad_pkg::*;

  localparam int DW  = 12;
  localparam int CW  = 16;
  localparam int OPW = DW + 3;
  localparam int PRW = DW + CW + 2;
`ifdef BQ_MULT_PIPE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif

  logic           clk = 1'b0;
  logic           nreset = 1'b0;
  logic           clear = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic [DW-1:0]  in_data = '0;
  logic [CW-1:0]  coef_b0 = '0, coef_b1 = '0, coef_b2 = '0, coef_a1 = '0, coef_a2 = '0;
  logic           in_ready, out_valid;
  logic [DW-1:0]  out_data;
  logic [CW-2:0]  mul_a;
  logic [OPW-1:0] mul_b;
  logic [PRW-1:0] mul_r;

  logic [CW-1:0]  c_b0 = '0, c_b1 = '0, c_b2 = '0, c_a1 = '0, c_a2 = '0;

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  // External unsigned multiplier.
  assign mul_r = PRW'(mul_a) * PRW'(mul_b);

  biquad_mac_sched dut (
    .clk       (clk),
    .nreset    (nreset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_b0   (coef_b0),
    .coef_b1   (coef_b1),
    .coef_b2   (coef_b2),
    .coef_a1   (coef_a1),
    .coef_a2   (coef_a2),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_r     (mul_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint cval(input logic [CW-1:0] c);
    longint v;
    v = longint'($signed(c));
    if (v == -32768) v = -32767;
    return v;
  endfunction

  // Behavioural model: the filter equation evaluated at the accept edge, plus timing bookkeeping.
  bit     m_busy = 1'b0;
  int     m_age = 0;
  longint m_y = 0;
  longint mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;

  always @(posedge clk or negedge nreset) begin
    longint acc, yf, xv;
    if (!nreset) begin
      m_busy = 1'b0; m_age = 0; m_y = 0;
      mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    end else if (!m_busy) begin
      if (clear) begin
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
      end else if (in_valid) begin
        xv  = longint'($signed(in_data));
        acc = cval(coef_b0) * xv + cval(coef_b1) * mx1 + cval(coef_b2) * mx2
            - cval(coef_a1) * my1 - cval(coef_a2) * my2;
        yf  = acc >>> SHIFT;
        m_y = sat(yf, DW);
        mx2 = mx1; mx1 = xv;
        my2 = my1; my1 = sat(yf, OPW);
        m_busy = 1'b1;
        m_age  = 1;
      end
    end else begin
      if (m_age >= LAT && out_ready) m_busy = 1'b0;
      else m_age++;
    end
  end

  // Per-cycle compare of the handshake outputs and the result against the model.
  always @(negedge clk) begin
    bit ev;
    if (run_chk && nreset) begin
      ev = m_busy && (m_age >= LAT);
      chk("out_valid", longint'(out_valid), longint'(ev));
      chk("in_ready", longint'(in_ready), longint'(!m_busy));
      if (ev) chk("out_data", longint'($signed(out_data)), m_y);
    end
  end

  task automatic set_coefs(input logic [CW-1:0] b0, b1, b2, a1, a2);
    c_b0 = b0; c_b1 = b1; c_b2 = b2; c_a1 = a1; c_a2 = a2;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; in_valid = 1'b1; in_data = DW'($urandom);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
  endtask

  // Send one sample, return the result, first-tap multiplier operands and edges-to-valid.
  task automatic send_get(input int x, input int hold, input bit poke, output int y,
                          output logic [CW-2:0] ma, output logic [OPW-1:0] mb, output int lat);
    int n;
    logic [DW-1:0] yfirst;
    n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", longint'(in_ready), 1);
    coef_b0 = c_b0; coef_b1 = c_b1; coef_b2 = c_b2; coef_a1 = c_a1; coef_a2 = c_a2;
    in_data = DW'(x); in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ma = mul_a; mb = mul_b;
    coef_b0 = CW'($urandom); coef_b1 = CW'($urandom); coef_b2 = CW'($urandom);
    coef_a1 = CW'($urandom); coef_a2 = CW'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("out_valid_wait", longint'(out_valid), 1);
    y = int'($signed(out_data));
    yfirst = out_data;
    if (hold > 0) begin
      if (poke) begin in_valid = 1'b1; clear = 1'b1; in_data = DW'($urandom); end
      repeat (hold) begin @(posedge clk); #1; end
      in_valid = 1'b0; clear = 1'b0;
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_data", longint'($signed(out_data)), longint'($signed(yfirst)));
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int y, lat, hold;
    logic [CW-2:0] ma;
    logic [OPW-1:0] mb;
    logic [CW-1:0] rc [5];

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_mul_a", longint'(mul_a), 0);
    chk("rst_mul_b", longint'(mul_b), 0);
    nreset = 1'b1;
    run_chk = 1'b1;
    @(posedge clk); #1;

    // Impulse
    set_coefs(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0);
    send_get(100, 0, 1'b0, y, ma, mb, lat);
    chk("imp_mul_a", longint'(ma), 16'h4000);
    chk("imp_mul_b", longint'(mb), 100);
    chk("imp_latency", lat, LAT - 1);
    chk("imp_y0", y, 100);
    send_get(0, 0, 1'b0, y, ma, mb, lat); chk("imp_y1", y, 0);
    send_get(0, 0, 1'b0, y, ma, mb, lat); chk("imp_y2", y, 0);

    // Feedback with a1 = -0.5
    pulse_clear();
    set_coefs(16'h4000, 16'h0, 16'h0, 16'hE000, 16'h0);
    send_get(100, 0, 1'b0, y, ma, mb, lat); chk("fb_y0", y, 100);
    send_get(0, 0, 1'b0, y, ma, mb, lat);   chk("fb_y1", y, 50);
    send_get(0, 0, 1'b0, y, ma, mb, lat);   chk("fb_y2", y, 25);
    send_get(0, 0, 1'b0, y, ma, mb, lat);   chk("fb_y3", y, 12);

    // Saturation
    pulse_clear();
    set_coefs(16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0);
    send_get(2047, 0, 1'b0, y, ma, mb, lat);  chk("sat_pos", y, 2047);
    send_get(-2048, 0, 1'b0, y, ma, mb, lat); chk("sat_neg", y, -2048);

    // Backpressure, with in_valid and clear poked while held in OUT
    pulse_clear();
    set_coefs(16'h4000, 16'h0, 16'h0, 16'hE000, 16'h0);
    send_get(-300, 10, 1'b1, y, ma, mb, lat); chk("bp_y", y, -300);
    send_get(0, 0, 1'b0, y, ma, mb, lat);     chk("bp_clear_ignored", y, -150);

    // Reset in MAC at tap 2 after building up history
    set_coefs(16'h4000, 16'h2000, 16'h0, 16'hE000, 16'h0);
    send_get(500, 0, 1'b0, y, ma, mb, lat);
    send_get(300, 0, 1'b0, y, ma, mb, lat);
    coef_b0 = c_b0; coef_b1 = c_b1; coef_b2 = c_b2; coef_a1 = c_a1; coef_a2 = c_a2;
    in_data = DW'(77); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    nreset = 1'b0;
    #1;
    chk("mid_rst_in_ready", longint'(in_ready), 1);
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_out_data", longint'(out_data), 0);
    chk("mid_rst_mul_a", longint'(mul_a), 0);
    @(posedge clk); #1;
    nreset = 1'b1;
    @(posedge clk); #1;
    send_get(100, 0, 1'b0, y, ma, mb, lat); chk("post_rst_y", y, 100);

    // Most-negative coefficient clamp
    pulse_clear();
    set_coefs(16'h8000, 16'h0, 16'h0, 16'h0, 16'h0);
    send_get(1, 0, 1'b0, y, ma, mb, lat);
    chk("clamp_mul_a", longint'(ma), 16'h7FFF);
    chk("clamp_y", y, -2);

    // Randomized stream; the compare process checks every result against the model.
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 15) == 0) rc[k] = 16'h8000;
        else rc[k] = CW'($urandom_range(0, 32767)) - 16'd16384;
      end
      set_coefs(rc[0], rc[1], rc[2], rc[3], rc[4]);
      if ($urandom_range(0, 9) == 0) pulse_clear();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      send_get(int'($signed(DW'($urandom))), hold, 1'($urandom_range(0, 1)), y, ma, mb, lat);
    end

    run_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
